// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states, default
// operand width and the control-strobe index map used by datapath and control.
package booth_pkg;

  localparam int BOOTH_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    STEP   = 3'd3,
    OUT_A  = 3'd4,
    OUT_Q  = 3'd5
  } booth_state_t;

  // Bit positions of c0..c7 when the strobes are carried as one vector.
  localparam int C_INIT   = 0;
  localparam int C_LOAD_M = 1;
  localparam int C_SUB    = 2;
  localparam int C_LOAD_Q = 3;
  localparam int C_STEP   = 4;
  localparam int C_OUT_A  = 5;
  localparam int C_OUT_Q  = 6;
  localparam int C_OPEN   = 7;

endpackage

// File: rtl/booth_step_cnt.sv
// Booth step counter: synchronous clear, count enable, terminal-count flag
// raised when the count reaches WIDTH-1.
module booth_step_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: loads M and Q, runs WIDTH add/shift steps, then
// reads A and Q out. Strobes are registered Moore outputs; c2/c7 decode live.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7,
  output logic busy,
  output logic done
);

  booth_state_t r_state;
  logic         w_tc;
  logic         w_cnt_clr;
  logic         w_cnt_en;

  // Counter is zeroed leaving LOAD_Q and held at WIDTH-1 on the final step.
  assign w_cnt_clr = (r_state == LOAD_Q);
  assign w_cnt_en  = (r_state == STEP) && !w_tc;

  booth_step_cnt #(
    .WIDTH (WIDTH)
  ) u_step_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Outputs are assigned together with the next state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      c0      <= 1'b0;
      c1      <= 1'b0;
      c3      <= 1'b0;
      c4      <= 1'b0;
      c5      <= 1'b0;
      c6      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      c0   <= 1'b0;
      c1   <= 1'b0;
      c3   <= 1'b0;
      c4   <= 1'b0;
      c5   <= 1'b0;
      c6   <= 1'b0;
      done <= 1'b0;
      busy <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD_M;
            c0      <= 1'b1;
            c1      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD_M: begin
          r_state <= LOAD_Q;
          c3      <= 1'b1;
        end
        LOAD_Q: begin
          r_state <= STEP;
          c4      <= 1'b1;
        end
        STEP: begin
          if (w_tc) begin
            r_state <= OUT_A;
            c5      <= 1'b1;
          end else begin
            c4 <= 1'b1;
          end
        end
        OUT_A: begin
          r_state <= OUT_Q;
          c6      <= 1'b1;
          done    <= 1'b1;
        end
        OUT_Q: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    c2 = 1'b0;
    c7 = 1'b0;
    if (r_state == STEP) begin
      case ({q0, q_m1})
        2'b01: c7 = 1'b1;
        2'b10: begin
          c7 = 1'b1;
          c2 = 1'b1;
        end
        default: begin
          c7 = 1'b0;
          c2 = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: reset, nominal sequence, Booth decode, abort,
// start-while-busy, back-to-back starts and a WIDTH=4 instance.
module tb_booth_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       q0;
  logic       q_m1;
  logic [7:0] c8;
  logic       busy8;
  logic       done8;
  logic       start4;
  logic [7:0] c4v;
  logic       busy4;
  logic       done4;
  logic [9:0] obs8;
  logic [9:0] obs4;

  int vectors;
  int miscompares;
  int c4_count;
  int done_count;

  // Expected words, bit order {c0,c1,c2,c3,c4,c5,c6,c7,busy,done}
  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_LDM   = 10'b1100000010;
  localparam logic [9:0] V_LDQ   = 10'b0001000010;
  localparam logic [9:0] V_STP00 = 10'b0000100010;
  localparam logic [9:0] V_STP10 = 10'b0010100110;
  localparam logic [9:0] V_STP01 = 10'b0000100110;
  localparam logic [9:0] V_OUTA  = 10'b0000010010;
  localparam logic [9:0] V_OUTQ  = 10'b0000001011;

  booth_ctrl #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .q0   (q0),
    .q_m1 (q_m1),
    .c0   (c8[0]),
    .c1   (c8[1]),
    .c2   (c8[2]),
    .c3   (c8[3]),
    .c4   (c8[4]),
    .c5   (c8[5]),
    .c6   (c8[6]),
    .c7   (c8[7]),
    .busy (busy8),
    .done (done8)
  );

  booth_ctrl #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .start(start4),
    .q0   (1'b0),
    .q_m1 (1'b0),
    .c0   (c4v[0]),
    .c1   (c4v[1]),
    .c2   (c4v[2]),
    .c3   (c4v[3]),
    .c4   (c4v[4]),
    .c5   (c4v[5]),
    .c6   (c4v[6]),
    .c7   (c4v[7]),
    .busy (busy4),
    .done (done4)
  );

  assign obs8 = {c8[0], c8[1], c8[2], c8[3], c8[4], c8[5], c8[6], c8[7], busy8, done8};
  assign obs4 = {c4v[0], c4v[1], c4v[2], c4v[3], c4v[4], c4v[5], c4v[6], c4v[7], busy4, done4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe word for cycle c of a sequence with {q0,q_m1}=00.
  function automatic logic [9:0] exp_seq(input int c, input int w);
    if (c == 1)                     return V_LDM;
    else if (c == 2)                return V_LDQ;
    else if (c >= 3 && c <= w + 2)  return V_STP00;
    else if (c == w + 3)            return V_OUTA;
    else if (c == w + 4)            return V_OUTQ;
    else                            return V_IDLE;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic b);
    start = s;
    q0    = a;
    q_m1  = b;
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full WIDTH=8 run from cycle 0; optional stray start pulses in cycles 4 and 11.
  task automatic seq8(input string tag, input bit stray);
    c4_count   = 0;
    done_count = 0;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) nxt();
      drive((c == 0) || (stray && (c == 4 || c == 11)), 1'b0, 1'b0);
      chk($sformatf("%s_cyc%0d", tag, c), obs8, exp_seq(c, 8));
      if (c8[4] === 1'b1) c4_count++;
      if (done8 === 1'b1) done_count++;
    end
    chk1($sformatf("%s_c4_count8", tag), (c4_count == 8), 1'b1);
    chk1($sformatf("%s_done_once", tag), (done_count == 1), 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    start  = 1'b1;
    q0     = 1'b0;
    q_m1   = 1'b0;
    start4 = 1'b0;

    // Reset held two cycles with start asserted
    nxt();
    chk("rst_cyc1", obs8, V_IDLE);
    nxt();
    chk("rst_cyc2", obs8, V_IDLE);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    nxt();
    chk("post_rst_idle", obs8, V_IDLE);
    nxt();

    // Nominal sequence
    seq8("nominal", 1'b0);
    nxt();

    // Booth decode: LOAD_Q ignores the pair, STEP decodes it in the same cycle
    drive(1'b1, 1'b0, 1'b0);
    chk("dec_cyc0", obs8, V_IDLE);
    nxt();
    drive(1'b0, 1'b1, 1'b0);
    chk("dec_ldm_pair10", obs8, V_LDM);
    nxt();
    drive(1'b0, 1'b1, 1'b0);
    chk("dec_ldq_pair10", obs8, V_LDQ);
    nxt();
    drive(1'b0, 1'b1, 1'b0);
    chk("dec_step_10", obs8, V_STP10);
    nxt();
    drive(1'b0, 1'b0, 1'b1);
    chk("dec_step_01", obs8, V_STP01);
    nxt();
    drive(1'b0, 1'b1, 1'b1);
    chk("dec_step_11", obs8, V_STP00);
    nxt();
    drive(1'b0, 1'b0, 1'b0);
    chk("dec_step_00", obs8, V_STP00);
    for (int c = 7; c <= 13; c++) begin
      nxt();
      drive(1'b0, 1'b1, 1'b0);
      chk($sformatf("dec_tail_cyc%0d", c), obs8,
          (c <= 10) ? V_STP10 : exp_seq(c, 8));
    end
    nxt();

    // Abort in the 5th STEP cycle
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      nxt();
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("abort_cyc%0d", c), obs8, exp_seq(c, 8));
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    chk("abort_idle", obs8, V_IDLE);
    done_count = 0;
    for (int c = 0; c < 6; c++) begin
      nxt();
      #1;
      chk($sformatf("abort_quiet%0d", c), obs8, V_IDLE);
    end
    seq8("after_abort", 1'b0);
    nxt();

    // Start pulses while busy are ignored
    seq8("busy_ign", 1'b1);
    nxt();

    // Start held high: done every WIDTH+5 cycles
    done_count = 0;
    for (int c = 0; c <= 39; c++) begin
      if (c > 0) nxt();
      drive((c <= 38), 1'b0, 1'b0);
      chk1($sformatf("b2b_done_cyc%0d", c), done8, (c == 12 || c == 25 || c == 38));
      if (done8 === 1'b1) done_count++;
    end
    chk1("b2b_done_count3", (done_count == 3), 1'b1);
    nxt();
    #1;
    chk("b2b_idle_after", obs8, V_IDLE);

    // WIDTH=4 instance
    c4_count   = 0;
    done_count = 0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) nxt();
      start4 = (c == 0);
      #1;
      chk($sformatf("w4_cyc%0d", c), obs4, exp_seq(c, 4));
      if (c4v[4] === 1'b1) c4_count++;
      if (done4 === 1'b1) done_count++;
    end
    chk1("w4_c4_count4", (c4_count == 4), 1'b1);
    chk1("w4_done_once", (done_count == 1), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
